// File: rtl/frame_buffer_if.sv
// Write/read/flip signal bundle between the load controller, the display scanner
// and the double-buffered frame memory.
interface frame_buffer_if #(
   parameter int unsigned W    = 24,
   parameter int unsigned RowW = 3,
   parameter int unsigned ColW = 5
);
   logic [W-1:0]    wdata;
   logic            wen;
   logic [RowW-1:0] wrow;
   logic [ColW-1:0] wcol;
   logic            loaded;
   logic            ready;
   logic            ren;
   logic [RowW-1:0] rrow;
   logic [ColW-1:0] rcol;
   logic [W-1:0]    rdata;
   logic            rvalid;
   logic            frame_end;
   logic            front_sel;

   modport master (
      output wdata, wen, wrow, wcol, loaded, ren, rrow, rcol, frame_end,
      input  ready, rdata, rvalid, front_sel
   );

   modport slave (
      input  wdata, wen, wrow, wcol, loaded, ren, rrow, rcol, frame_end,
      output ready, rdata, rvalid, front_sel
   );
endinterface

// File: rtl/frame_buffer.sv
// Double-buffered frame memory: writes land in the back buffer, registered reads come
// from the front buffer, and an armed flip swaps them at the next scanner frame boundary.
module frame_buffer #(
   parameter int unsigned Segments = 1,
   parameter int unsigned Rows     = 8,
   parameter int unsigned Columns  = 32,
   parameter int unsigned Bitwidth = 8
) (
   input logic            clk,
   input logic            rst,
   frame_buffer_if.slave  bus
);
   localparam int unsigned W    = Segments * Bitwidth * 3;
   localparam int unsigned RowW = (Rows > 1) ? $clog2(Rows) : 1;
   localparam int unsigned ColW = (Columns > 1) ? $clog2(Columns) : 1;

   typedef enum logic [0:0] {StIdle, StArmed} state_e;

   logic [W-1:0] r_mem0 [Rows][Columns];
   logic [W-1:0] r_mem1 [Rows][Columns];

   state_e       r_state, w_state_d;
   logic         r_ready, w_ready_d;
   logic         r_front_sel, w_front_sel_d;
   logic [W-1:0] r_rdata;
   logic         r_rvalid;

   logic         w_wrow_ok, w_wcol_ok, w_rrow_ok, w_rcol_ok;
   logic         w_wr_en;
   logic [W-1:0] w_rd_word;

   // Range checks only exist for non-power-of-2 sizes; otherwise every address is valid.
   if (Rows == (1 << RowW)) begin : g_row_full
      assign w_wrow_ok = 1'b1;
      assign w_rrow_ok = 1'b1;
   end else begin : g_row_part
      assign w_wrow_ok = (32'(bus.wrow) < Rows);
      assign w_rrow_ok = (32'(bus.rrow) < Rows);
   end

   if (Columns == (1 << ColW)) begin : g_col_full
      assign w_wcol_ok = 1'b1;
      assign w_rcol_ok = 1'b1;
   end else begin : g_col_part
      assign w_wcol_ok = (32'(bus.wcol) < Columns);
      assign w_rcol_ok = (32'(bus.rcol) < Columns);
   end

   assign w_wr_en = bus.wen && r_ready && w_wrow_ok && w_wcol_ok;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         if (r_front_sel) begin
            r_mem0[bus.wrow][bus.wcol] <= bus.wdata;
         end else begin
            r_mem1[bus.wrow][bus.wcol] <= bus.wdata;
         end
      end
   end

   always_comb begin
      w_rd_word = '0;
      if (w_rrow_ok && w_rcol_ok) begin
         w_rd_word = r_front_sel ? r_mem1[bus.rrow][bus.rcol] : r_mem0[bus.rrow][bus.rcol];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= bus.ren;
         if (bus.ren) begin
            r_rdata <= w_rd_word;
         end
      end
   end

   // Arming and flipping are exclusive per cycle, so a flip never lands in its arming cycle.
   always_comb begin
      w_state_d     = r_state;
      w_ready_d     = r_ready;
      w_front_sel_d = r_front_sel;
      unique case (r_state)
         StIdle: begin
            if (bus.loaded) begin
               w_state_d = StArmed;
               w_ready_d = 1'b0;
            end
         end
         StArmed: begin
            if (bus.frame_end) begin
               w_state_d     = StIdle;
               w_ready_d     = 1'b1;
               w_front_sel_d = ~r_front_sel;
            end
         end
         default: begin
            w_state_d = StIdle;
            w_ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= StIdle;
         r_ready     <= 1'b1;
         r_front_sel <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_ready     <= w_ready_d;
         r_front_sel <= w_front_sel_d;
      end
   end

   assign bus.ready     = r_ready;
   assign bus.front_sel = r_front_sel;
   assign bus.rdata     = r_rdata;
   assign bus.rvalid    = r_rvalid;
endmodule

// File: tb/tb_frame_buffer.sv
// Bench for frame_buffer: a per-cycle reference model of both buffers and the flip
// protocol, plus directed scenarios with literal expected values.
module tb_frame_buffer;
   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   frame_buffer_if #(.W(24), .RowW(3), .ColW(5)) bus ();

   frame_buffer #(
      .Segments (1),
      .Rows     (8),
      .Columns  (32),
      .Bitwidth (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: buffer contents, which one is displayed, and whether a flip is owed.
   logic [23:0] m_mem [2][8][32];
   logic        m_front;
   logic        m_pending;
   logic        m_ready;
   logic [23:0] m_rdata;
   logic        m_rvalid;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_front   <= 1'b0;
         m_pending <= 1'b0;
         m_ready   <= 1'b1;
         m_rdata   <= 24'h0;
         m_rvalid  <= 1'b0;
      end else begin
         m_rvalid <= bus.ren;
         if (bus.ren) m_rdata <= m_mem[m_front][bus.rrow][bus.rcol];
         if (bus.wen && m_ready) m_mem[!m_front][bus.wrow][bus.wcol] <= bus.wdata;
         if (m_pending) begin
            if (bus.frame_end) begin
               m_front   <= !m_front;
               m_pending <= 1'b0;
               m_ready   <= 1'b1;
            end
         end else if (bus.loaded) begin
            m_pending <= 1'b1;
            m_ready   <= 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      check("model ready", {31'h0, bus.ready}, {31'h0, m_ready});
      check("model front_sel", {31'h0, bus.front_sel}, {31'h0, m_front});
      check("model rvalid", {31'h0, bus.rvalid}, {31'h0, m_rvalid});
      check("model rdata", {8'h0, bus.rdata}, {8'h0, m_rdata});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] r, input logic [4:0] c, input logic [23:0] d);
      bus.wen = 1'b1; bus.wrow = r; bus.wcol = c; bus.wdata = d;
      tick();
      bus.wen = 1'b0;
   endtask

   task automatic rd(input logic [2:0] r, input logic [4:0] c,
                     output logic [23:0] d, output logic v);
      bus.ren = 1'b1; bus.rrow = r; bus.rcol = c;
      tick();
      bus.ren = 1'b0;
      d = bus.rdata;
      v = bus.rvalid;
   endtask

   task automatic pulse_loaded();
      bus.loaded = 1'b1;
      tick();
      bus.loaded = 1'b0;
   endtask

   task automatic pulse_fe();
      bus.frame_end = 1'b1;
      tick();
      bus.frame_end = 1'b0;
   endtask

   task automatic fill_back_zero();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 32; c++) wr(3'(r), 5'(c), 24'h0);
   endtask

   logic [23:0] d;
   logic        v;

   initial begin
      n_pass = 0;
      n_total = 0;
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 32; c++) m_mem[b][r][c] = 24'h0;
      rst = 1'b0;
      bus.wdata = '0; bus.wen = 1'b0; bus.wrow = '0; bus.wcol = '0;
      bus.loaded = 1'b0; bus.ren = 1'b0; bus.rrow = '0; bus.rcol = '0;
      bus.frame_end = 1'b0;
      #12 rst = 1'b1;
      tick();

      // Give both buffers known contents, ending with buffer 0 in front.
      fill_back_zero();
      pulse_loaded();
      pulse_fe();
      fill_back_zero();
      pulse_loaded();
      pulse_fe();

      // Reset again; memory contents survive, control state does not.
      rst = 1'b0;
      #3;
      check("reset ready", {31'h0, bus.ready}, 32'h1);
      check("reset front_sel", {31'h0, bus.front_sel}, 32'h0);
      check("reset rvalid", {31'h0, bus.rvalid}, 32'h0);
      check("reset rdata", {8'h0, bus.rdata}, 32'h0);
      rst = 1'b1;
      tick();

      // Write to back, read old front, then flip and read the new data.
      wr(3'd2, 5'd5, 24'hA1B2C3);
      rd(3'd2, 5'd5, d, v);
      check("old front rdata", {8'h0, d}, 32'h0);
      check("old front rvalid", {31'h0, v}, 32'h1);
      pulse_loaded();
      pulse_fe();
      check("flip1 front_sel", {31'h0, bus.front_sel}, 32'h1);
      check("flip1 ready", {31'h0, bus.ready}, 32'h1);
      rd(3'd2, 5'd5, d, v);
      check("new front rdata", {8'h0, d}, 32'hA1B2C3);

      // A write while locked is dropped.
      pulse_loaded();
      check("locked ready", {31'h0, bus.ready}, 32'h0);
      wr(3'd0, 5'd0, 24'hFFFFFF);
      pulse_fe();
      rd(3'd0, 5'd0, d, v);
      check("dropped write", {8'h0, d}, 32'h0);

      // loaded and frame_end together only arm.
      bus.loaded = 1'b1; bus.frame_end = 1'b1;
      tick();
      bus.loaded = 1'b0; bus.frame_end = 1'b0;
      check("arm only front_sel", {31'h0, bus.front_sel}, 32'h0);
      check("arm only ready", {31'h0, bus.ready}, 32'h0);
      repeat (9) tick();
      pulse_fe();
      check("late flip front_sel", {31'h0, bus.front_sel}, 32'h1);
      check("late flip ready", {31'h0, bus.ready}, 32'h1);

      // Double loaded gives one flip; extra frame_end pulses do nothing.
      pulse_loaded();
      tick();
      pulse_loaded();
      pulse_fe();
      check("single flip", {31'h0, bus.front_sel}, 32'h0);
      pulse_fe();
      tick();
      pulse_fe();
      check("no extra flip", {31'h0, bus.front_sel}, 32'h0);

      // A read in the flip cycle sees the old front; the next one sees the new front.
      wr(3'd3, 5'd7, 24'h5A5A5A);
      pulse_loaded();
      bus.ren = 1'b1; bus.rrow = 3'd3; bus.rcol = 5'd7; bus.frame_end = 1'b1;
      tick();
      bus.frame_end = 1'b0;
      check("flip cycle read", {8'h0, bus.rdata}, 32'h0);
      tick();
      bus.ren = 1'b0;
      check("post flip read", {8'h0, bus.rdata}, 32'h5A5A5A);
      check("post flip front_sel", {31'h0, bus.front_sel}, 32'h1);

      // Asynchronous reset while armed, with a read result outstanding.
      pulse_loaded();
      bus.ren = 1'b1; bus.rrow = 3'd2; bus.rcol = 5'd5;
      @(posedge clk);
      #3;
      check("pre reset rvalid", {31'h0, bus.rvalid}, 32'h1);
      rst = 1'b0;
      #1;
      bus.ren = 1'b0;
      check("async ready", {31'h0, bus.ready}, 32'h1);
      check("async front_sel", {31'h0, bus.front_sel}, 32'h0);
      check("async rvalid", {31'h0, bus.rvalid}, 32'h0);
      #2 rst = 1'b1;
      tick();
      wr(3'd1, 5'd1, 24'hC0FFEE);
      pulse_loaded();
      pulse_fe();
      rd(3'd1, 5'd1, d, v);
      check("after reset flip", {8'h0, d}, 32'hC0FFEE);

      // Same address written and read in one cycle: different buffers.
      bus.wen = 1'b1; bus.wrow = 3'd1; bus.wcol = 5'd1; bus.wdata = 24'h777777;
      bus.ren = 1'b1; bus.rrow = 3'd1; bus.rcol = 5'd1;
      tick();
      bus.wen = 1'b0; bus.ren = 1'b0;
      check("same addr read", {8'h0, bus.rdata}, 32'hC0FFEE);
      pulse_loaded();
      pulse_fe();
      rd(3'd1, 5'd1, d, v);
      check("same addr write", {8'h0, d}, 32'h777777);

      #20;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
Double-buffered frame memory directly downstream of the SPI load controller. Accepts column writes (wdata/wen/wrow/wcol) into the back buffer and serves registered reads from the front buffer to the display scanner. On the controller's `loaded` pulse it arms a flip. The flip executes at the scanner's next frame boundary, and `ready` then rises to tell the controller the back buffer is writable again.

Parameters:
segments, 1, number of panel segments packed per column word
rows, 8, addressable rows per buffer
columns, 32, columns per row
bitwidth, 8, bits per colour channel; word width W = segments*bitwidth*3

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
wdata  input  W  column word from load controller
wen  input  1  write strobe, one-cycle pulse
wrow  input  $clog2(rows)  write row address
wcol  input  $clog2(columns)  write column address
loaded  input  1  one-cycle pulse: back buffer fully populated, request flip
ready  output  1  back buffer writable; 0->1 edge signals a flip completed
ren  input  1  scanner read request
rrow  input  $clog2(rows)  read row address
rcol  input  $clog2(columns)  read column address
rdata  output  W  read data from front buffer
rvalid  output  1  rdata valid, one-cycle pulse
frame_end  input  1  scanner pulse: last row/column of a full scan finished
front_sel  output  1  index (0/1) of buffer currently displayed

Behaviour:
- Storage: two arrays, each rows*columns words of W bits, indexed row*columns+col. Contents are not reset; reset clears control state only.
- Reset (rst=0, asynchronous) values: ready=1, front_sel=0, pending=0, rdata=0, rvalid=0.
- Write path:
  - A write occurs when wen=1 and ready=1. It stores to buffer ~front_sel at [wrow][wcol] at the clock edge.
  - Writes while ready=0 are dropped, so a locked back buffer is never corrupted.
  - A write with wrow>=rows or wcol>=columns is dropped. This only matters for non-power-of-2 sizes.
- Read path:
  - ren=1 at cycle N gives rdata=front[rrow][rcol] and rvalid=1 at N+1 (1-cycle latency).
  - With ren=0, rvalid=0 and rdata holds its last value.
  - An out-of-range read address returns 0 with rvalid=1.
  - The read uses the front_sel value sampled in the same cycle as ren. A read issued in the flip cycle returns old-front data.
- Flip state machine, two states:
  - IDLE (pending=0, ready=1): when loaded=1, go to ARMED: pending<=1, ready<=0 next cycle. A wen in the same cycle as loaded is still accepted.
  - ARMED (pending=1, ready=0): when frame_end=1, front_sel<=~front_sel, pending<=0, ready<=1, return to IDLE. The flip takes effect on the cycle after frame_end.
  - loaded while ARMED: ignored. No double flip; the flip count stays 1.
  - loaded and frame_end in the same cycle while IDLE: only arms. The flip waits for the next frame_end; a flip never occurs in the cycle it is armed.
  - frame_end while IDLE: no effect.
- ready is registered, so its 0->1 edge lasts at least one cycle for the controller's edge detector.
- Reset asserted mid-ARMED: returns to IDLE with front_sel=0. A pending flip is lost; the controller reloads.
- Write and read are independent. Simultaneous wen and ren on the same address never conflict, because they target different buffers.

Test Plan:
- Reset, then wen to row 2 col 5 with wdata=0xA1B2C3, then read row 2 col 5 -> rdata=0x000000 (old front, unwritten, front_sel=0). Then loaded then frame_end -> front_sel=1, ready=1; re-read -> rdata=0xA1B2C3 one cycle after ren.
- loaded pulse -> ready=0 next cycle. wen to row 0 col 0 with 0xFFFFFF while ready=0 -> after flip, front[0][0] keeps its prior value.
- loaded and frame_end in the same cycle from IDLE -> front_sel unchanged, ready=0. A second frame_end 10 cycles later -> front_sel toggles, ready=1 on the following cycle.
- Two loaded pulses before frame_end -> exactly one toggle of front_sel. Two further frame_end pulses -> no further toggles.
- ren issued in the same cycle as frame_end (ARMED) -> rdata from the old front buffer. ren on the next cycle -> new front data.
- Drive rst=0 asynchronously (mid-cycle) while ARMED -> ready=1, front_sel=0, rvalid=0 immediately, without waiting for a clock edge. After release, a normal write/load/flip sequence works.
